// File: rtl/l2_request_arbiter.sv
// rtl/l2_request_arbiter.sv - round-robin arbiter sharing the L2 request port through a 2-entry skid FIFO
package l2_request_pkg;
    typedef enum logic [2:0] {
        L2_LOAD       = 3'd0,
        L2_STORE      = 3'd1,
        L2_STORE_SYNC = 3'd2,
        L2_IFETCH     = 3'd3,
        L2_ATOMIC     = 3'd4
    } l2req_type_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  id;
        logic [31:0] address;
        logic [63:0] data;
        logic [7:0]  store_mask;
        l2req_type_e packet_type;
        logic [1:0]  cache_type;
        logic [3:0]  core;
    } l2req_packet_t;
endpackage

module l2_request_arbiter
    import l2_request_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  l2req_packet_t [NUM_CORES-1:0]  core_request,
    output logic [NUM_CORES-1:0]           core_ready,
    output l2req_packet_t                  arb_request,
    input  logic                           l2_pipe_ready
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [1:0]           count;
    l2req_packet_t        entry0, entry1;
    logic [PTR_W-1:0]     rr_ptr, rr_next, winner, cand;
    logic [NUM_CORES-1:0] req;
    logic                 found, can_accept, enq, deq;
    l2req_packet_t        grant_pkt;
    int                   idx;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            req[i] = core_request[i].valid;
        end
    end

    // Scan from rr_ptr upward, wrapping, and take the first requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int o = 0; o < NUM_CORES; o++) begin
            idx  = (int'(rr_ptr) + o) % NUM_CORES;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Only registered count gates acceptance, keeping l2_pipe_ready off the core_ready path.
    assign can_accept  = (count != 2'd2);
    assign core_ready  = (can_accept && found) ? (NUM_CORES'(1) << winner) : '0;
    assign enq         = |core_ready;
    assign deq         = (count != 2'd0) && l2_pipe_ready;
    assign grant_pkt   = core_request[winner];
    assign arb_request = (count != 2'd0) ? entry0 : '0;
    assign rr_next     = (int'(winner) == NUM_CORES - 1) ? '0 : winner + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
            rr_ptr <= '0;
        end else begin
            if (enq) begin
                rr_ptr <= rr_next;
            end
            case ({enq, deq})
                2'b10: begin
                    if (count == 2'd0) entry0 <= grant_pkt;
                    else               entry1 <= grant_pkt;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    entry1 <= '0;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= grant_pkt;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= grant_pkt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(core_ready)) else $error("core_ready not onehot0: %b", core_ready);
            assert (count <= 2'd2) else $error("skid count overflow: %0d", count);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_request[i].valid) begin
                    assert (int'(core_request[i].core) == i)
                        else $error("core_request[%0d] carries core %0d", i, core_request[i].core);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb/tb_l2_request_arbiter.sv - directed-vector bench for l2_request_arbiter
module tb_l2_request_arbiter;
    import l2_request_pkg::*;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    l2req_packet_t [N-1:0] core_request;
    logic [N-1:0]          core_ready;
    l2req_packet_t         arb_request;
    logic                  l2_pipe_ready;

    int n_vec = 0;
    int n_err = 0;

    l2req_packet_t pk [6];
    l2req_packet_t exp_q [$];
    l2req_packet_t prev, tmp, p_a0, p_a0b, p_b1;
    int            pk_idx, delivered, ec, granted;

    always #5 clk = ~clk;

    l2_request_arbiter #(.NUM_CORES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_request (core_request),
        .core_ready   (core_ready),
        .arb_request  (arb_request),
        .l2_pipe_ready(l2_pipe_ready)
    );

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset         = 1'b1;
        core_request  = '0;
        l2_pipe_ready = 1'b0;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    function automatic l2req_packet_t mk(input int core, input logic [3:0] id, input logic [31:0] addr,
                                         input l2req_type_e t, input logic [63:0] data, input logic [7:0] mask);
        l2req_packet_t p;
        p             = '0;
        p.valid       = 1'b1;
        p.id          = id;
        p.address     = addr;
        p.data        = data;
        p.store_mask  = mask;
        p.packet_type = t;
        p.cache_type  = 2'b01;
        p.core        = 4'(core);
        return p;
    endfunction

    initial begin
        // 1: reset then a single LOAD from core 2
        do_reset(2);
        tmp = mk(2, 4'd3, 32'h1000, L2_LOAD, 64'h0, 8'h0);
        core_request[2] = tmp;
        l2_pipe_ready   = 1'b1;
        @(negedge clk);
        check_vec("t1_reset_count", 128'(dut.count), 128'(0));
        check_vec("t1_reset_rr_ptr", 128'(dut.rr_ptr), 128'(0));
        check_vec("t1_no_bypass", 128'(arb_request), 128'(0));
        check_vec("t1_ready_c0", 128'(core_ready), 128'(4'b0100));
        tick();
        core_request[2] = '0;
        @(negedge clk);
        check_vec("t1_arb_c1", 128'(arb_request), 128'(tmp));
        check_vec("t1_addr_c1", 128'(arb_request.address), 128'(32'h1000));
        tick();
        @(negedge clk);
        check_vec("t1_count_c2", 128'(dut.count), 128'(0));
        check_vec("t1_empty_c2", 128'(arb_request.valid), 128'(0));

        // 2: all cores request continuously
        do_reset(1);
        l2_pipe_ready = 1'b1;
        for (int i = 0; i < N; i++) core_request[i] = mk(i, 4'(i), 32'h2000 + 32'(i), L2_LOAD, 64'h0, 8'h0);
        prev = '0;
        for (int c = 0; c < 12; c++) begin
            ec = c % N;
            @(negedge clk);
            check_vec("t2_grant", 128'(core_ready), 128'(4'(1) << ec));
            check_vec("t2_arb", 128'(arb_request), 128'(prev));
            prev = core_request[ec];
            tick();
            core_request[ec] = mk(ec, 4'(c), 32'h2000 + 32'(c * 16 + ec), L2_LOAD, 64'h0, 8'h0);
        end

        // 3: backpressure fills the FIFO
        do_reset(1);
        p_a0  = mk(0, 4'd1, 32'h3000, L2_LOAD, 64'h0, 8'h0);
        p_a0b = mk(0, 4'd2, 32'h3040, L2_LOAD, 64'h0, 8'h0);
        p_b1  = mk(1, 4'd1, 32'h3100, L2_STORE, 64'h1234, 8'h0F);
        core_request[0] = p_a0;
        core_request[1] = p_b1;
        @(negedge clk);
        check_vec("t3_grant0", 128'(core_ready), 128'(4'b0001));
        tick();
        core_request[0] = p_a0b;
        @(negedge clk);
        check_vec("t3_grant1", 128'(core_ready), 128'(4'b0010));
        tick();
        core_request[1] = '0;
        @(negedge clk);
        check_vec("t3_full_ready", 128'(core_ready), 128'(0));
        check_vec("t3_full_count", 128'(dut.count), 128'(2));
        check_vec("t3_full_head", 128'(arb_request), 128'(p_a0));
        tick();
        l2_pipe_ready = 1'b1;
        @(negedge clk);
        check_vec("t3_deq_ready", 128'(core_ready), 128'(0));
        check_vec("t3_deq_head", 128'(arb_request), 128'(p_a0));
        tick();
        @(negedge clk);
        check_vec("t3_resume_count", 128'(dut.count), 128'(1));
        check_vec("t3_resume_ready", 128'(core_ready), 128'(4'b0001));
        check_vec("t3_resume_head", 128'(arb_request), 128'(p_b1));
        tick();
        core_request[0] = '0;
        @(negedge clk);
        check_vec("t3_last_head", 128'(arb_request), 128'(p_a0b));
        tick();
        @(negedge clk);
        check_vec("t3_drained", 128'(arb_request.valid), 128'(0));

        // 4: pointer wrap
        do_reset(1);
        l2_pipe_ready   = 1'b1;
        core_request[2] = mk(2, 4'd0, 32'h4000, L2_LOAD, 64'h0, 8'h0);
        @(negedge clk);
        check_vec("t4_grant2", 128'(core_ready), 128'(4'b0100));
        tick();
        core_request[2] = '0;
        core_request[0] = mk(0, 4'd1, 32'h4100, L2_LOAD, 64'h0, 8'h0);
        core_request[3] = mk(3, 4'd2, 32'h4300, L2_LOAD, 64'h0, 8'h0);
        @(negedge clk);
        check_vec("t4_rr3", 128'(dut.rr_ptr), 128'(3));
        check_vec("t4_grant3", 128'(core_ready), 128'(4'b1000));
        tick();
        core_request[3] = '0;
        @(negedge clk);
        check_vec("t4_rr0", 128'(dut.rr_ptr), 128'(0));
        check_vec("t4_grant0", 128'(core_ready), 128'(4'b0001));
        tick();
        core_request[0] = '0;

        // 5: STORE_SYNC integrity under random backpressure
        do_reset(1);
        for (int i = 0; i < 6; i++)
            pk[i] = mk(1, 4'd2, 32'h5000 + 32'(i * 64), L2_STORE_SYNC, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
        pk_idx          = 0;
        delivered       = 0;
        core_request[1] = pk[0];
        for (int cyc = 0; cyc < 200 && delivered < 6; cyc++) begin
            l2_pipe_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            granted = int'(core_ready[1]);
            if (arb_request.valid && l2_pipe_ready) begin
                if (exp_q.size() == 0) begin
                    check_vec("t5_spurious", 128'(arb_request), 128'(0));
                end else begin
                    tmp = exp_q.pop_front();
                    check_vec("t5_pkt", 128'(arb_request), 128'(tmp));
                    delivered++;
                end
            end
            if (granted != 0) exp_q.push_back(core_request[1]);
            tick();
            if (granted != 0) begin
                pk_idx++;
                core_request[1] = (pk_idx < 6) ? pk[pk_idx] : '0;
            end
        end
        check_vec("t5_delivered", 128'(delivered), 128'(6));
        check_vec("t5_leftover", 128'(exp_q.size()), 128'(0));

        // 6: reset with two packets buffered
        do_reset(1);
        core_request[0] = mk(0, 4'd5, 32'h6000, L2_LOAD, 64'h0, 8'h0);
        core_request[1] = mk(1, 4'd6, 32'h6100, L2_LOAD, 64'h0, 8'h0);
        tick();
        core_request[0] = '0;
        tick();
        core_request[1] = '0;
        @(negedge clk);
        check_vec("t6_full_count", 128'(dut.count), 128'(2));
        reset        = 1'b1;
        core_request = '0;
        tick();
        reset         = 1'b0;
        l2_pipe_ready = 1'b1;
        @(negedge clk);
        check_vec("t6_post_valid", 128'(arb_request.valid), 128'(0));
        check_vec("t6_post_ready", 128'(core_ready), 128'(0));
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            check_vec("t6_never_emitted", 128'(arb_request.valid), 128'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
